// File: rtl/seq_div8_restoring_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default width and the quotient presented on divide-by-zero.
package div_pkg;

    localparam int WIDTH_DEF = 8;

    // Wide enough for any practical WIDTH; the top slices off what it needs.
    localparam logic [63:0] DIV0_Q = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_div8_restoring_if.sv
// Operand/result bus of the divider, shared in shape with the multiplier tops.
// master drives start and operands; slave returns results and status.
interface seq_div8_restoring_if
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             busy;
    logic             done;
    logic             dz;

    modport master (
        output start, A, B,
        input  Q, R, busy, done, dz
    );

    modport slave (
        input  start, A, B,
        output Q, R, busy, done, dz
    );

endinterface

// File: rtl/seq_div8_restoring_sub9b.sv
// Ripple-borrow subtractor S = X - Y built as X + ~Y + 1 over chained full-adder cells.
// Purely combinational; borrow is the inverted final carry.
module fa1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

module sub9b #(
    parameter int N = 9
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] s,
    output logic         borrow
);

    logic [N:0] c;

    assign c[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bit
            fa1 u_fa (
                .a  (x[i]),
                .b  (~y[i]),
                .ci (c[i]),
                .s  (s[i]),
                .co (c[i+1])
            );
        end
    endgenerate

    assign borrow = ~c[N];

endmodule

// File: rtl/seq_div8_restoring.sv
// Restoring unsigned divider Q=A/B, R=A%B, one quotient bit per clock.
// Latency WIDTH+2 edges start->done (2 for B=0); start is ignored while busy, nothing is queued.
module seq_div8_restoring
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_div8_restoring_if.slave  bus
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic             dz_r;
    logic             done_r;
    logic [WIDTH:0]   part;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic             fits;
    logic             last_iter;

    assign part      = {rem_r, quo_r[WIDTH-1]};
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    sub9b #(
        .N (WIDTH + 1)
    ) u_sub (
        .x      (part),
        .y      ({1'b0, div_r}),
        .s      (trial),
        .borrow (borrow)
    );

    // rem_r < div_r keeps a successful trial below 2^WIDTH, so its MSB is zero here.
    assign fits = ~borrow & ~trial[WIDTH];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = (bus.B == '0) ? S_FIN : S_CALC;
            S_CALC:  if (last_iter) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            rem_r  <= '0;
            quo_r  <= '0;
            div_r  <= '0;
            q_r    <= '0;
            r_r    <= '0;
            dz_r   <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        quo_r <= bus.A;
                        div_r <= bus.B;
                        rem_r <= '0;
                        cnt   <= '0;
                        dz_r  <= 1'b0;
                    end
                end
                S_CALC: begin
                    rem_r <= fits ? trial[WIDTH-1:0] : part[WIDTH-1:0];
                    quo_r <= {quo_r[WIDTH-2:0], fits};
                    cnt   <= cnt + CNT_W'(1);
                end
                S_FIN: begin
                    done_r <= 1'b1;
                    // A zero divisor skips CALC, so quo_r still holds the captured dividend.
                    if (div_r == '0) begin
                        q_r  <= DIV0_Q[WIDTH-1:0];
                        r_r  <= quo_r;
                        dz_r <= 1'b1;
                    end else begin
                        q_r  <= quo_r;
                        r_r  <= rem_r;
                        dz_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Q    = q_r;
    assign bus.R    = r_r;
    assign bus.dz   = dz_r;
    assign bus.done = done_r;
    assign bus.busy = (state == S_CALC) || (state == S_FIN);

endmodule

// File: tb/tb_seq_div8_restoring.sv
// Directed bench for seq_div8_restoring: hand-computed vectors, handshake timing and a strided sweep.
module tb_seq_div8_restoring;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   lat;
    int   nbusy;

    seq_div8_restoring_if #(.WIDTH(8)) bus ();

    seq_div8_restoring #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present operands for one cycle; b2b=1 drives start in the current (done) cycle.
    task automatic launch(input logic [7:0] a, input logic [7:0] b, input bit b2b);
        if (!b2b) @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = 8'($urandom);
        bus.B     = 8'($urandom);
    endtask

    // Entered one negedge after the accept edge; lat_o counts edges from accept to done.
    task automatic wait_done(output int lat_o, output int busy_o);
        lat_o  = 1;
        busy_o = 0;
        while (!bus.done && lat_o < 40) begin
            if (bus.busy) busy_o++;
            @(negedge clk);
            lat_o++;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;

        #12;
        check("rst_q",    32'(bus.Q), 0);
        check("rst_r",    32'(bus.R), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_dz",   32'(bus.dz), 0);
        @(negedge clk);
        rst_n = 1'b1;

        launch(8'd200, 8'd7, 1'b0);
        wait_done(lat, nbusy);
        check("d200_7_lat",  32'(lat), 10);
        check("d200_7_busy", 32'(nbusy), 9);
        check("d200_7_q",    32'(bus.Q), 28);
        check("d200_7_r",    32'(bus.R), 4);
        check("d200_7_dz",   32'(bus.dz), 0);
        check("busy_at_done", 32'(bus.busy), 0);
        @(negedge clk);
        check("done_pulse", 32'(bus.done), 0);
        @(negedge clk);
        check("hold_q", 32'(bus.Q), 28);
        check("hold_r", 32'(bus.R), 4);

        launch(8'd255, 8'd1, 1'b0);
        wait_done(lat, nbusy);
        check("d255_1_lat", 32'(lat), 10);
        check("d255_1_q",   32'(bus.Q), 255);
        check("d255_1_r",   32'(bus.R), 0);
        launch(8'd5, 8'd9, 1'b1);
        wait_done(lat, nbusy);
        check("d5_9_lat", 32'(lat), 10);
        check("d5_9_q",   32'(bus.Q), 0);
        check("d5_9_r",   32'(bus.R), 5);
        launch(8'd255, 8'd255, 1'b1);
        wait_done(lat, nbusy);
        check("d255_255_lat", 32'(lat), 10);
        check("d255_255_q",   32'(bus.Q), 1);
        check("d255_255_r",   32'(bus.R), 0);

        launch(8'd144, 8'd0, 1'b0);
        wait_done(lat, nbusy);
        check("dz_lat", 32'(lat), 2);
        check("dz_q",   32'(bus.Q), 255);
        check("dz_r",   32'(bus.R), 144);
        check("dz_flag", 32'(bus.dz), 1);
        launch(8'd189, 8'd190, 1'b1);
        wait_done(lat, nbusy);
        check("d189_190_lat", 32'(lat), 10);
        check("d189_190_q",   32'(bus.Q), 0);
        check("d189_190_r",   32'(bus.R), 189);
        check("d189_190_dz",  32'(bus.dz), 0);

        launch(8'd200, 8'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'd10;
        bus.B     = 8'd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat, nbusy);
        check("ign_lat", 32'(lat + 3), 10);
        check("ign_q",   32'(bus.Q), 28);
        check("ign_r",   32'(bus.R), 4);
        @(negedge clk);
        check("ign_not_queued", 32'(bus.busy), 0);

        launch(8'd200, 8'd7, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_q",    32'(bus.Q), 0);
        check("arst_r",    32'(bus.R), 0);
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_done", 32'(bus.done), 0);
        check("arst_dz",   32'(bus.dz), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        launch(8'd249, 8'd153, 1'b0);
        wait_done(lat, nbusy);
        check("d249_153_lat", 32'(lat), 10);
        check("d249_153_q",   32'(bus.Q), 1);
        check("d249_153_r",   32'(bus.R), 96);

        for (int a = 0; a < 256; a += 17) begin
            for (int b = 1; b < 256; b += 13) begin
                launch(8'(a), 8'(b), 1'b0);
                wait_done(lat, nbusy);
                check($sformatf("sw_lat_%0d_%0d", a, b), 32'(lat), 10);
                check($sformatf("sw_id_%0d_%0d", a, b),
                      32'(int'(bus.Q) * b + int'(bus.R)), 32'(a));
                check($sformatf("sw_rlt_%0d_%0d", a, b), (int'(bus.R) < b) ? 32'd1 : 32'd0, 32'd1);
                check($sformatf("sw_dz_%0d_%0d", a, b), 32'(bus.dz), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
